// File: rtl/block_reader.sv
// block_reader: streams a window of consecutive words from the product memory
// read port to a valid/ready consumer. A 2-entry buffer absorbs the one-cycle
// memory read latency, so consumer backpressure never loses data.
module block_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN_blockRead,
    input  logic [ADDR_W-1:0] blockRead_base,
    input  logic [ADDR_W:0]   blockRead_len,
    output logic              RDY_blockRead,
    output logic              EN_readMem,
    output logic [ADDR_W-1:0] readMem_addr,
    input  logic [DATA_W-1:0] readMem_val,
    output logic              VALID_memVal,
    output logic [DATA_W-1:0] memVal_data,
    output logic              LAST_memVal,
    input  logic              RDY_memVal,
    output logic              DONE_blockRead
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LP_LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LP_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;        // next address to read
    logic [ADDR_W:0]     r_issue_left;  // reads still to issue
    logic [ADDR_W:0]     r_xfer_left;   // words still to hand to the consumer
    logic                r_inflight;    // a read was issued last cycle
    logic [1:0]          r_count;       // buffer occupancy, 0..2
    logic                r_wptr;
    logic                r_rptr;
    logic [DATA_W-1:0]   r_buf [2];
    logic                r_done;

    logic                w_accept;
    logic                w_xfer;
    logic                w_issue;
    logic                w_done_nxt;
    logic [ADDR_W:0]     w_len_clamped;
    logic [2:0]          w_occ_after;

    assign w_accept = EN_blockRead && (r_state == ST_IDLE);
    assign w_xfer   = (r_count != 2'd0) && RDY_memVal;

    // Slots that stay committed once this cycle's transfer leaves the buffer.
    assign w_occ_after = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_xfer};

    // Clamp the requested length to the memory depth.
    always_comb begin
        w_len_clamped = blockRead_len;
        if (blockRead_len > LP_DEPTH) begin
            w_len_clamped = LP_DEPTH;
        end else begin
            w_len_clamped = blockRead_len;
        end
    end

    // Next-state, read-issue and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_len_clamped != {(ADDR_W+1){1'b0}})) begin
                    w_state_nxt = ST_READ;
                end else if (w_accept) begin
                    w_done_nxt  = 1'b1;   // empty block completes immediately
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                w_issue = (w_occ_after < 3'd2);
                if (w_issue && (r_issue_left == LP_LEN_ONE)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (w_xfer && (r_xfer_left == LP_LEN_ONE)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, counters, address and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= {ADDR_W{1'b0}};
            r_issue_left <= {(ADDR_W+1){1'b0}};
            r_xfer_left  <= {(ADDR_W+1){1'b0}};
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_addr       <= blockRead_base;
                r_issue_left <= w_len_clamped;
                r_xfer_left  <= w_len_clamped;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + LP_ADDR_ONE;   // wraps mod DEPTH
                    r_issue_left <= r_issue_left - LP_LEN_ONE;
                end
                if (w_xfer) begin
                    r_xfer_left <= r_xfer_left - LP_LEN_ONE;
                end
            end
        end
    end

    // Two-entry output FIFO: captures read data one cycle after each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf[0] <= {DATA_W{1'b0}};
            r_buf[1] <= {DATA_W{1'b0}};
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_buf[r_wptr] <= readMem_val;
                r_wptr        <= ~r_wptr;
            end
            if (w_xfer) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
        end
    end

    assign RDY_blockRead  = (r_state == ST_IDLE);
    assign EN_readMem     = w_issue;
    assign readMem_addr   = r_addr;
    assign VALID_memVal   = (r_count != 2'd0);
    assign memVal_data    = r_buf[r_rptr];
    assign LAST_memVal    = VALID_memVal && (r_xfer_left == LP_LEN_ONE);
    assign DONE_blockRead = r_done;

endmodule

// File: tb/tb_block_reader.sv
// Self-checking bench for block_reader: behavioural memory, expected word
// lists built from base/len arithmetic, randomized backpressure and blocks.
module tb_block_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN_blockRead;
    logic [5:0]  blockRead_base;
    logic [6:0]  blockRead_len;
    logic        RDY_blockRead;
    logic        EN_readMem;
    logic [5:0]  readMem_addr;
    logic [31:0] readMem_val;
    logic        VALID_memVal;
    logic [31:0] memVal_data;
    logic        LAST_memVal;
    logic        RDY_memVal;
    logic        DONE_blockRead;

    logic [31:0] mem [64];
    int n_vec = 0;
    int n_err = 0;

    block_reader #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .EN_blockRead(EN_blockRead), .blockRead_base(blockRead_base),
        .blockRead_len(blockRead_len), .RDY_blockRead(RDY_blockRead),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(readMem_val), .VALID_memVal(VALID_memVal),
        .memVal_data(memVal_data), .LAST_memVal(LAST_memVal),
        .RDY_memVal(RDY_memVal), .DONE_blockRead(DONE_blockRead)
    );

    always #5 clk = ~clk;

    // Behavioural memory: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        if (EN_readMem) readMem_val <= mem[readMem_addr];
        else            readMem_val <= $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: consumer always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic do_block(input int base, input int len, input int mode, input bit poke);
        int n, issued, got, last_x, first_v, c;
        bit done_seen, prev_stall, xfer;
        logic [31:0] prev_data;
        logic prev_last;
        logic [31:0] expq [$];
        n = (len > 64) ? 64 : len;
        issued = 0; got = 0; last_x = -1; first_v = -1;
        done_seen = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < n; i++) expq.push_back(mem[(base + i) % 64]);
        @(negedge clk);
        #1;
        chk("rdy_before_req", RDY_blockRead, 1);
        EN_blockRead = 1'b1;
        blockRead_base = base[5:0];
        blockRead_len = len[6:0];
        RDY_memVal = 1'b0;
        @(negedge clk);
        EN_blockRead = 1'b0;
        for (c = 0; c < n * 6 + 20 && !done_seen; c++) begin
            if (c > 0) @(negedge clk);
            case (mode)
                0: RDY_memVal = 1'b1;
                1: RDY_memVal = (c % 3 == 0);
                default: RDY_memVal = $urandom_range(0, 1);
            endcase
            if (poke && got < n) begin
                EN_blockRead = $urandom_range(0, 1);
                blockRead_base = $urandom;
                blockRead_len = $urandom;
            end else begin
                EN_blockRead = 1'b0;
            end
            #1;
            xfer = VALID_memVal && RDY_memVal;
            if (LAST_memVal) chk("last_needs_valid", VALID_memVal, 1);
            if (n == 0) chk("rdy_len0", RDY_blockRead, 1);
            if (prev_stall) begin
                chk("stall_valid", VALID_memVal, 1);
                chk("stall_data", memVal_data, prev_data);
                chk("stall_last", LAST_memVal, prev_last);
            end
            if (EN_readMem) begin
                chk("read_addr", readMem_addr, (base + issued) % 64);
                issued++;
                chk("read_not_extra", issued <= n, 1);
            end
            chk("occupancy_le_2", (issued - got - int'(xfer)) <= 2, 1);
            if (xfer) begin
                chk("word_in_range", got < n, 1);
                if (got < n) begin
                    chk("data", memVal_data, expq[got]);
                    chk("last", LAST_memVal, got == n - 1);
                end
                got++;
                last_x = c;
                if (first_v < 0) first_v = c;
            end
            prev_stall = VALID_memVal && !RDY_memVal;
            prev_data = memVal_data;
            prev_last = LAST_memVal;
            if (DONE_blockRead) begin
                chk("done_timing", c - last_x, 1);
                chk("done_count", got, n);
                chk("rdy_at_done", RDY_blockRead, 1);
                done_seen = 1;
            end
        end
        EN_blockRead = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("reads_issued", issued, n);
        if (mode == 0 && n > 0) begin
            chk("first_valid_latency", first_v, 2);
            chk("streaming_contiguous", last_x - first_v, n - 1);
        end
        @(negedge clk);
        #1;
        chk("done_single_pulse", DONE_blockRead, 0);
    endtask

    initial begin
        rst = 1'b1; EN_blockRead = 1'b0; blockRead_base = '0; blockRead_len = '0;
        RDY_memVal = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = i * 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy", RDY_blockRead, 1);
        chk("rst_en_read", EN_readMem, 0);
        chk("rst_addr", readMem_addr, 0);
        chk("rst_valid", VALID_memVal, 0);
        chk("rst_data", memVal_data, 0);
        chk("rst_last", LAST_memVal, 0);
        chk("rst_done", DONE_blockRead, 0);

        do_block(0, 4, 0, 0);      // 0,3,6,9 stream, LAST on 9
        do_block(62, 4, 0, 0);     // wrap 62,63,0,1
        do_block(10, 8, 1, 0);     // backpressure 1,0,0,...
        do_block(7, 0, 0, 0);      // empty block
        do_block(5, 100, 0, 1);    // clamped to 64, ignored requests mid-block
        do_block(20, 1, 0, 0);     // back-to-back single words
        do_block(21, 1, 1, 0);

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int k = 0; k < 6; k++)
            do_block($urandom_range(0, 63), $urandom_range(1, 20), 2, $urandom_range(0, 1));
        do_block($urandom_range(0, 63), $urandom_range(65, 127), 2, 0);

        // reset in the middle of a stalled block
        @(negedge clk);
        EN_blockRead = 1'b1; blockRead_base = 6'd30; blockRead_len = 7'd8; RDY_memVal = 1'b0;
        @(negedge clk);
        EN_blockRead = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_valid", VALID_memVal, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", VALID_memVal, 0);
        chk("midrst_rdy", RDY_blockRead, 1);
        chk("midrst_done", DONE_blockRead, 0);
        chk("midrst_en_read", EN_readMem, 0);
        @(negedge clk);
        #1;
        chk("midrst_valid_late", VALID_memVal, 0);
        chk("midrst_done_late", DONE_blockRead, 0);
        do_block(33, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
